// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MIPS opcodes, instruction field positions and
// the hazard controller state type.
package pipeline_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic {RUN, FLUSH} estado_t;

  // Opcodes whose rt field is a source operand (not a destination).
  function automatic logic usa_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/contador_sat.sv
// W-bit up counter with enable and synchronous reset that holds at all-ones.
module contador_sat #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/control_riesgos_if_id.sv
// IF/ID hazard controller: load-use stalls, taken-branch flushes and
// instruction-memory waits, with saturating stall/flush statistics.
module control_riesgos_if_id
  import pipeline_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruccion,
  input  logic             imem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] RELOAD = 2'(FLUSH_CYCLES - 1);

  estado_t    state_reg, state_next;
  logic [1:0] flush_left_reg, flush_left_next;
  logic       ex_memread_q;
  logic [4:0] ex_rt_q;
  logic       stall_en, flush_en;

  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       load_use;

  assign op = instruccion[OP_MSB:OP_LSB];
  assign rs = instruccion[RS_MSB:RS_LSB];
  assign rt = instruccion[RT_MSB:RT_LSB];

  assign load_use = ex_memread_q && (ex_rt_q != 5'd0) &&
                    ((ex_rt_q == rs) || (usa_rt(op) && (ex_rt_q == rt)));

  always_comb begin
    state_next      = state_reg;
    flush_left_next = flush_left_reg;
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    idex_bubble     = 1'b0;
    stall_en        = 1'b0;
    flush_en        = 1'b0;

    if (rst) begin
      pc_write    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_en    = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_next      = FLUSH;
        flush_left_next = RELOAD;
      end else begin
        state_next      = RUN;
        flush_left_next = 2'd0;
      end
    end else if (state_reg == FLUSH) begin
      ifid_flush      = 1'b1;
      idex_bubble     = 1'b1;
      flush_en        = 1'b1;
      flush_left_next = flush_left_reg - 2'd1;
      if (flush_left_reg == 2'd1) begin
        state_next = RUN;
      end
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_en    = 1'b1;
    end else if (!imem_ready) begin
      // ID instruction still advances; a NOP fills IF/ID while memory waits.
      pc_write   = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      flush_left_reg <= 2'd0;
      ex_memread_q   <= 1'b0;
      ex_rt_q        <= 5'd0;
    end else begin
      state_reg      <= state_next;
      flush_left_reg <= flush_left_next;
      if (idex_bubble) begin
        ex_memread_q <= 1'b0;
        ex_rt_q      <= 5'd0;
      end else begin
        ex_memread_q <= (op == OP_LW);
        ex_rt_q      <= rt;
      end
    end
  end

  contador_sat #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_en),
    .q   (stall_cnt)
  );

  contador_sat #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (flush_en),
    .q   (flush_cnt)
  );

endmodule
